// File: rtl/mem_port_arbiter.sv
// Purpose : serialises fetch (read-only) and load/store accesses onto one single-ported memory.
// Latency : request sampled at edge N -> ack during cycle after edge N+MEM_LAT+1 (MEM_LAT+2 cycles);
//           one access per MEM_LAT+3 cycles back-to-back.
// Backpressure: requests are level req/ack; a requester stalls on req && !ack, nothing is queued here.
//
// Ports:
//   clk, reset                - rising-edge clock, asynchronous active-high reset
//   i_req/i_addr/i_ack/i_rdata - fetch port (read only)
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata - load/store port
//   busy                      - high while an access is in progress
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory macro interface
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both ports
// request together; otherwise the data port always wins a tie.

module mem_port_arbiter #(
   parameter int XLEN    = 32,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_ack,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_ack,
   output logic [XLEN-1:0] d_rdata,
   output logic            busy,
   output logic            mem_en,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAT = CNT_W'(MEM_LAT);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_owner_d;    // 1 = data port owns the current access
   logic              r_i_ack;
   logic              r_d_ack;
   logic [XLEN-1:0]   r_i_rdata;
   logic [XLEN-1:0]   r_d_rdata;
   logic              r_busy;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [XLEN-1:0]   r_mem_addr;
   logic [XLEN-1:0]   r_mem_wdata;

   logic              w_any_req;
   logic              w_grant_d;

   assign w_any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_rr_last_d;               // 1 = last grant went to the data port

   // On a tie, hand the grant to whoever did not win last time.
   assign w_grant_d = d_req & (~i_req | ~r_rr_last_d);
`else
   // Data port wins ties: the older instruction in MEM must never wait on fetch.
   assign w_grant_d = d_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_owner_d   <= 1'b1;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_busy      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_rr_last_d <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  // Everything the memory needs is captured here; requester
                  // changes after this edge have no effect on this access.
                  r_owner_d   <= w_grant_d;
                  r_mem_addr  <= w_grant_d ? d_addr : i_addr;
                  r_mem_we    <= w_grant_d & d_we;
                  r_mem_wdata <= w_grant_d ? d_wdata : '0;
                  r_mem_en    <= 1'b1;
                  r_cnt       <= LP_LAT;
                  r_busy      <= 1'b1;
                  r_state     <= S_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                  r_rr_last_d <= w_grant_d;
`endif
               end
            end
            S_WAIT: begin
               r_mem_en <= 1'b0;
               if (r_cnt == '0) begin
                  // Stores complete with the same timing but leave read data alone.
                  if (r_owner_d) begin
                     r_d_ack <= 1'b1;
                     if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                     end
                  end else begin
                     r_i_ack   <= 1'b1;
                     r_i_rdata <= mem_rdata;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               // Requests are deliberately not sampled here so the requester
               // has this cycle to drop or refresh its req after seeing ack.
               r_i_ack <= 1'b0;
               r_d_ack <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_i_ack  <= 1'b0;
               r_d_ack  <= 1'b0;
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign i_ack     = r_i_ack;
   assign d_ack     = r_d_ack;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign busy      = r_busy;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : randomized and directed stimulus for mem_port_arbiter with a scoreboard.
// Latency : expected strobes/acks are timestamped by edge number from the access rules.
// Backpressure: requesters hold req until ack, then drop or refresh in the ack cycle.

module tb_mem_port_arbiter;

   localparam int XLEN = 32;
   localparam int ML   = 2;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            i_req = 1'b0;
   logic [XLEN-1:0] i_addr = '0;
   logic            i_ack;
   logic [XLEN-1:0] i_rdata;
   logic            d_req = 1'b0;
   logic            d_we = 1'b0;
   logic [XLEN-1:0] d_addr = '0;
   logic [XLEN-1:0] d_wdata = '0;
   logic            d_ack;
   logic [XLEN-1:0] d_rdata;
   logic            busy;
   logic            mem_en;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(XLEN), .MEM_LAT(ML), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          edge_n;
   } acc_t;

   acc_t        ack_q[$];
   acc_t        mem_q[$];
   logic [31:0] ref_mem[128];
   logic [31:0] mem_arr[128];
   int          checks = 0;
   int          errors = 0;
   int          edge_cnt = 0;
   int          free_edge = 0;
   int          busy_until = -1;
   bit          rr_last_d = 1'b0;
   logic [31:0] exp_i_rdata = '0;
   logic [31:0] exp_d_rdata = '0;

   function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, got, exp, edge_cnt);
      end
   endfunction

   // Memory macro: data appears MEM_LAT edges after the strobe edge, junk before.
   int          pend_cnt = 0;
   logic [31:0] pend_data;
   always @(posedge clk) begin
      if (mem_en) begin
         pend_data = mem_arr[mem_addr[8:2]];
         if (mem_we) mem_arr[mem_addr[8:2]] = mem_wdata;
         pend_cnt = ML - 1;
         if (pend_cnt == 0) mem_rdata <= pend_data;
         else               mem_rdata <= $urandom;
      end else if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) mem_rdata <= pend_data;
      end
   end

   // Reference model: an access is granted on any edge with a request once the
   // port is free; it strobes at that edge, acks MEM_LAT+1 edges later, and the
   // port is free again MEM_LAT+3 edges after the grant.
   always @(posedge clk) begin
      acc_t a;
      bit   gd;
      edge_cnt++;
      if (reset) begin
         ack_q.delete();
         mem_q.delete();
         free_edge   = 0;
         busy_until  = -1;
         rr_last_d   = 1'b0;
         exp_i_rdata = '0;
         exp_d_rdata = '0;
      end else if (edge_cnt >= free_edge && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
         gd = (i_req && d_req) ? !rr_last_d : d_req;
         rr_last_d = gd;
`else
         gd = d_req;
`endif
         a.is_d   = gd;
         a.we     = gd && d_we;
         a.addr   = gd ? d_addr : i_addr;
         a.wdata  = d_wdata;
         a.rdata  = ref_mem[a.addr[8:2]];
         if (a.we) ref_mem[a.addr[8:2]] = a.wdata;
         a.edge_n = edge_cnt;
         ack_q.push_back(a);
         mem_q.push_back(a);
         free_edge  = edge_cnt + ML + 3;
         busy_until = edge_cnt + ML + 1;
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      acc_t e;
      if (reset === 1'b0) begin
         check("ack_exclusive", 32'(i_ack & d_ack), 32'd0);
         if (mem_en) begin
            if (mem_q.size() == 0) begin
               check("mem_en_unexpected", 32'(mem_en), 32'd0);
            end else begin
               e = mem_q.pop_front();
               check("mem_edge", 32'(edge_cnt), 32'(e.edge_n));
               check("mem_addr", mem_addr, e.addr);
               check("mem_we", 32'(mem_we), 32'(e.we));
               if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
         end else if (mem_q.size() != 0 && mem_q[0].edge_n < edge_cnt) begin
            e = mem_q.pop_front();
            check("mem_en_missing", 32'(mem_en), 32'd1);
         end

         if (i_ack || d_ack) begin
            if (ack_q.size() == 0) begin
               check("ack_unexpected", {30'd0, d_ack, i_ack}, 32'd0);
            end else begin
               e = ack_q.pop_front();
               check("ack_owner_d", 32'(d_ack), 32'(e.is_d));
               check("ack_edge", 32'(edge_cnt), 32'(e.edge_n + ML + 1));
               if (!e.we) begin
                  if (e.is_d) exp_d_rdata = e.rdata;
                  else        exp_i_rdata = e.rdata;
               end
            end
         end else if (ack_q.size() != 0 && ack_q[0].edge_n + ML + 1 < edge_cnt) begin
            e = ack_q.pop_front();
            check("ack_missing", 32'(i_ack | d_ack), 32'd1);
         end

         check("busy", 32'(busy), 32'(edge_cnt <= busy_until));
         check("i_rdata", i_rdata, exp_i_rdata);
         check("d_rdata", d_rdata, exp_d_rdata);
      end
   end

   task automatic wait_ack(input bit want_d);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (want_d ? d_ack : i_ack) return;
      end
      check(want_d ? "d_ack_timeout" : "i_ack_timeout", 32'(want_d ? d_ack : i_ack), 32'd1);
   endtask

   function automatic logic [31:0] rand_addr();
      return {23'd0, 7'($urandom_range(0, 127)), 2'b00};
   endfunction

   task automatic rand_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (i_ack || !i_req) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = rand_addr();
         end else if ($urandom_range(0, 7) == 0) begin
            i_addr = rand_addr();
         end
         if (d_ack || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = rand_addr();
            d_wdata = $urandom;
         end else if ($urandom_range(0, 31) == 0) begin
            d_req = 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            d_addr  = rand_addr();
            d_wdata = $urandom;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {27'd0, i_ack, d_ack, busy, mem_en, mem_we}, 32'd0);
      check({tag, "_i_rdata"}, i_rdata, 32'd0);
      check({tag, "_d_rdata"}, d_rdata, 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 128; k++) begin
         ref_mem[k] = $urandom;
         mem_arr[k] = ref_mem[k];
      end
      ref_mem[4] = 32'h0050_0093;
      mem_arr[4] = 32'h0050_0093;

      reset = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Single fetch from 0x10.
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h10;
      wait_ack(1'b0);
      check("t1_i_rdata", i_rdata, 32'h0050_0093);
      i_req = 1'b0;

      // Store 0xDEADBEEF to 0x100.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      wait_ack(1'b0 | 1'b1);
      d_req = 1'b0; d_we = 1'b0;

      // Both ports held together; the load reads back the stored word.
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h20;
      d_req = 1'b1; d_addr = 32'h100;
      wait_ack(1'b1);
      check("t3_d_rdata", d_rdata, 32'hDEAD_BEEF);
      d_req = 1'b0;
      wait_ack(1'b0);
      i_req = 1'b0;

      // Fetch address changes one cycle after the grant.
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h20;
      @(negedge clk);
      i_addr = 32'h40;
      wait_ack(1'b0);
      i_req = 1'b0;

      // Fetch held for three back-to-back accesses.
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h8;
      repeat (3) wait_ack(1'b0);
      i_req = 1'b0;

      rand_cycles(2500);

      // Reset during the WAIT of a load, then a fresh load.
      i_req = 1'b0; d_req = 1'b0;
      repeat (8) @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      wait_ack(1'b1);
      d_req = 1'b0;

      rand_cycles(1500);

      i_req = 1'b0; d_req = 1'b0;
      repeat (20) @(negedge clk);
      check("drain_ack_q", 32'(ack_q.size()), 32'd0);
      check("drain_mem_q", 32'(mem_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (read-only) and the load/store stage (read/write).
- Load/store requests come from the control decode (MemWrite / ResultSrc=01).
- Fixed-latency memory model. Requester handshake is req/ack. Requests are serialised through a 3-state FSM.
- Sits between the pipeline front end, the MEM stage and the memory macro. The pipeline stalls on req && !ack.

Parameters:
- XLEN, 32, address/data width.
- MEM_LAT, 2, memory read latency in cycles from the edge that samples mem_en. Legal range 1..15.
- CNT_W, 4, width of the latency down-counter. Must hold MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch read request, level, held until i_ack.
- i_addr  in  XLEN  fetch address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  XLEN  fetched word, valid in i_ack cycle, held afterwards.
- d_req  in  1  load/store request, level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  XLEN  load data, valid in d_ack cycle, held afterwards.
- busy  out  1  high while state != IDLE.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  XLEN  memory address, registered.
- mem_wdata  out  XLEN  memory write data, registered.
- mem_rdata  in  XLEN  read data, valid MEM_LAT cycles after the edge sampling mem_en, stable until the next mem_en.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: i_ack, d_ack, i_rdata, d_rdata, busy, mem_en, mem_we, mem_addr, mem_wdata. Counter=0, owner=D, rr_last=I.
- Reset asserted mid-transaction: the in-flight access is abandoned and no ack is issued. Memory side effects of an already-strobed store are not undone.
- All outputs are registered. No combinational path from req to ack or to mem_*.
- States:
  - IDLE: on an edge with any req, pick a winner (arbitration below). Latch owner, addr, we, wdata into mem_addr/mem_we/mem_wdata. Set mem_en=1, cnt=MEM_LAT, go WAIT. With no req, stay IDLE.
  - WAIT: mem_en=0 from the first WAIT cycle. cnt decrements each edge. On the edge with cnt==0, capture mem_rdata into the owner's rdata (loads and fetches only; a store leaves d_rdata unchanged), assert the owner's ack, go DONE.
  - DONE: the ack is high for exactly this cycle. The next edge clears the ack and goes IDLE. Requests are not sampled in DONE. The requester must drop or refresh req by the end of the DONE cycle; a req still high in IDLE is a new request.
- Latency: request sampled at edge N → mem_en high during cycle N..N+1 → ack high during cycle N+MEM_LAT+1..N+MEM_LAT+2. Request-to-ack latency = MEM_LAT+2 cycles. Back-to-back throughput = one access per MEM_LAT+3 cycles.
- Stores take the same latency as loads.
- Arbitration (default): fixed priority, D over I, because the older instruction must not deadlock behind fetch.
- Address, wdata and we are latched at grant. Later changes are ignored until the next grant.
- A requester dropping req mid-flight: the access still completes and the ack still pulses.
- i_ack and d_ack are never high in the same cycle.
- mem_en never re-asserts while busy=1.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both i_req and d_req are high in IDLE, grant the requester opposite to rr_last. rr_last updates on every grant. A single requester is always granted immediately.
- Undefined: fixed D-over-I priority; rr_last is not implemented.

Test Plan:
1. MEM_LAT=2; i_req=1, i_addr=0x0000_0010 sampled at edge 1 (memory returns 0x0050_0093) → mem_en=1, mem_we=0, mem_addr=0x10 for one cycle after edge 1. Then i_ack=1 and i_rdata=0x0050_0093 in the cycle after edge 4. busy high from after edge 1 to after edge 5.
2. Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → one mem_en pulse with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF. d_ack 4 cycles later; d_rdata unchanged.
3. i_req and d_req both high and held →
   - Default: D granted first; I granted at the IDLE after D's DONE; i_ack exactly 5 cycles after d_ack.
   - With ARB_ROUND_ROBIN_EN and requests held for 4 grants: sequence D, I, D, I.
4. i_addr changed from 0x20 to 0x40 one cycle after grant → mem_addr stays 0x20; i_rdata = word at 0x20.
5. reset pulsed during WAIT of a load → all outputs 0 asynchronously. No d_ack ever appears for that load. A fresh d_req after reset completes normally in MEM_LAT+2 cycles.
6. i_req held continuously for 3 accesses → exactly 3 i_ack pulses, spaced MEM_LAT+3 cycles apart. No mem_en while busy.
